// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the DMEM arbiter: grant encoding, arbiter FSM
// state encoding, conflict counter width and the DMEM geometry defaults.
// The geometry defaults must track the DMEM macro so the arbiter and the
// memory agree without per-instance overrides.

package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 11;
   localparam int DMEM_DATA_W = 32;

   localparam int CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_CPU  = 2'd1,
      GNT_DBG  = 2'd2
   } grant_e;

   typedef enum logic {
      ST_ARB     = 1'b0,
      ST_DBG_ACK = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port DMEM between the CPU (single-cycle access, stalled
// on conflict) and a debug/loader port (request held until a one-cycle ack).
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ARB      | arbitrate cpu_req / dbg_req, alternate on conflict
// DBG_ACK  | debug access done last cycle; pulse dbg_ack, serve CPU only
//
// Ports
//   clk_in, reset        clock, synchronous active-high reset
//   cpu_*                CPU request side; cpu_rdata combinational,
//                        cpu_stall when the CPU request is not served
//   dbg_*                debug request side; dbg_rdata registered,
//                        dbg_ack one-cycle completion pulse
//   dm_*                 DMEM strobes, address, write data, read data in
//   conflict_cnt         saturating count of CPU stall cycles

module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk_in,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              dbg_ack,
   output logic              dm_ena,
   output logic              dm_w,
   output logic              dm_r,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   state_e            state_q, state_d;
   grant_e            last_grant_q, last_grant_d;
   grant_e            grant;
   logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
   logic [CNT_W-1:0]  conflict_cnt_q, conflict_cnt_d;

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q        <= ST_ARB;
         last_grant_q   <= GNT_DBG;
         dbg_rdata_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         dbg_rdata_q    <= dbg_rdata_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end

   // Grant decision and next state. Reset holds the grant at NONE so the
   // memory sees no strobe while the arbiter is being cleared.
   always_comb begin
      grant        = GNT_NONE;
      state_d      = state_q;
      last_grant_d = last_grant_q;
      if (!reset) begin
         case (state_q)
            ST_ARB: begin
               if (cpu_req && dbg_req) begin
                  grant = (last_grant_q == GNT_CPU) ? GNT_DBG : GNT_CPU;
               end else if (cpu_req) begin
                  grant = GNT_CPU;
               end else if (dbg_req) begin
                  grant = GNT_DBG;
               end
            end
            ST_DBG_ACK: begin
               // dbg_req is still high here; it belongs to the access
               // already served, so only the CPU can be granted.
               if (cpu_req) begin
                  grant = GNT_CPU;
               end
               state_d = ST_ARB;
            end
            default: state_d = ST_ARB;
         endcase

         if (grant == GNT_DBG) begin
            state_d      = ST_DBG_ACK;
            last_grant_d = GNT_DBG;
         end else if (grant == GNT_CPU) begin
            last_grant_d = GNT_CPU;
         end
      end
   end

   // Kept apart from the grant process: dm_rdata returns through the
   // memory from dm_addr, which itself depends on the grant.
   always_comb begin
      dbg_rdata_d = dbg_rdata_q;
      if (grant == GNT_DBG && !dbg_we) begin
         dbg_rdata_d = dm_rdata;
      end
   end

   always_comb begin
      dm_ena   = 1'b0;
      dm_w     = 1'b0;
      dm_r     = 1'b0;
      dm_addr  = '0;
      dm_wdata = '0;
      case (grant)
         GNT_CPU: begin
            dm_ena   = 1'b1;
            dm_w     = cpu_we;
            dm_r     = !cpu_we;
            dm_addr  = cpu_addr;
            dm_wdata = cpu_wdata;
         end
         GNT_DBG: begin
            dm_ena   = 1'b1;
            dm_w     = dbg_we;
            dm_r     = !dbg_we;
            dm_addr  = dbg_addr;
            dm_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      cpu_stall = cpu_req && !reset && (grant != GNT_CPU);
      cpu_rdata = (grant == GNT_CPU) ? dm_rdata : '0;
      dbg_ack   = (state_q == ST_DBG_ACK) && !reset;
   end

   always_comb begin
      conflict_cnt_d = conflict_cnt_q;
      if (cpu_stall) begin
         conflict_cnt_d = sat_inc(conflict_cnt_q);
      end
   end

   assign dbg_rdata    = dbg_rdata_q;
   assign conflict_cnt = conflict_cnt_q;

endmodule
